trng_key_collector: RTL
=======================

# trng_key_collector

Control stage between the TRNG and the ChaCha20 key-input core inside `chacha20_system`. It requests 32-bit words from the TRNG using the request/ready handshake and health-checks each word. Each accepted word is written into the core's key registers as an indexed write strobe, and `key_loading_done` is raised once all 8 words (256 bits) are loaded. Repeated health failures and a stuck TRNG are reported on `error`; neither condition hangs the block.

## Interface
- `KEY_WORDS`, 8: key words to load; range 1..8.
- `TIMEOUT_CYCLES`, 256: maximum cycles spent waiting on either TRNG handshake edge.
- `MAX_RETRIES`, 4: consecutive rejected words that force `error`.

- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse that begins key generation. Ignored while `busy`.
- `trng_request`  out  1  request to the TRNG; registered.
- `trng_ready`  in  1  TRNG word valid; held high until `trng_request` falls.
- `trng_random_number`  in  32  TRNG word; valid while `trng_ready` is high.
- `key_write_enable`  out  1  one-cycle write strobe to the key-input core.
- `key_index`  out  3  key register index; meaningful only while `key_write_enable` is high.
- `key_word`  out  32  key word; equals the accepted word while the strobe is high, 0 otherwise.
- `key_loading_done`  out  1  all `KEY_WORDS` words written; held.
- `busy`  out  1  high in every state except IDLE, DONE and ERROR.
- `error`  out  1  health or timeout failure; held.

## Operation
- States: IDLE, REQ, WAIT_LOW, CHECK, WRITE, DONE, ERROR.
- **Reset:** all outputs are 0, the state is IDLE, and the word counter, retry counter, timeout counter, latched word and `have_prev` flag are all cleared. Reset mid-sequence aborts immediately. The key-input core keeps any partially written key.
- **IDLE, DONE, ERROR on `start`:**
  - Clear `key_loading_done`, `error`, the word count, the retry count and `have_prev`.
  - Go to REQ.
- **REQ:**
  - `trng_request` = 1.
  - On `trng_ready` = 1: latch `trng_random_number`, drop `trng_request`, go to WAIT_LOW.
- **WAIT_LOW:**
  - `trng_request` = 0.
  - On `trng_ready` = 0: go to CHECK.
- **CHECK:** the latched word is rejected if any of the following holds:
  - it equals 32'h00000000;
  - it equals 32'hFFFFFFFF;
  - `have_prev` is set and it equals the previously accepted word.
- **CHECK, accept:** retry count is cleared, the previous-word register is updated, `have_prev` is set, go to WRITE.
- **CHECK, reject:** retry count increments. If the new count equals `MAX_RETRIES`, go to ERROR; otherwise go to REQ. The word count is unchanged on reject.
- **WRITE:**
  - Drive `key_write_enable` = 1, `key_index` = word count, `key_word` = latched word, for exactly one cycle.
  - If word count = `KEY_WORDS`-1, go to DONE. Otherwise increment the word count and go to REQ.
- **DONE:** `key_loading_done` = 1 and `trng_request` = 0. The block stays here until `start` or `rst`.
- **ERROR:** `error` = 1 and `trng_request` = 0. The block stays here until `start` or `rst`.
- **Timeout:**
  - The timeout counter clears on every entry to REQ and to WAIT_LOW.
  - It increments every cycle spent in those states.
  - When it reaches `TIMEOUT_CYCLES`-1 without the awaited `trng_ready` level, go to ERROR with `trng_request` = 0.
- **Zeroization:** the latched word is cleared to 0 on leaving WRITE and on entering ERROR. The previous-word register is cleared when entering DONE and ERROR.

## Timing
- `start` sampled in cycle N gives `busy` = 1 and `trng_request` = 1 in cycle N+1.
- `trng_ready` sampled high in REQ gives `trng_request` = 0 on the next cycle.
- Per accepted word, the block spends:
  - 1 cycle in CHECK;
  - 1 cycle in WRITE (strobe);
  - REQ is re-entered the cycle after the strobe.
- A rejected word returns to REQ the cycle after CHECK.
- `key_loading_done` rises the cycle after the final strobe. `busy` falls in the same cycle.
- Minimum overhead beyond TRNG fill time is 4 cycles per word: REQ exit, WAIT_LOW, CHECK, WRITE.
- `start` coinciding with `rst`: reset wins.
- `start` while `busy`: no effect, no state change.
- Key strobes occur in strictly increasing `key_index` order, 0..`KEY_WORDS`-1, one per index. There are no duplicate or skipped strobes.

## Test plan
1. **Nominal load.** Reset, then `start`. The TRNG model returns 8 distinct valid words 0x11111111..0x88888888, each after 32 cycles. Required response:
   - 8 strobes with `key_index` 0..7 and matching `key_word`;
   - `key_loading_done` = 1;
   - `key_word` = 0 outside strobes.
2. **Health rejection.** The TRNG returns 0x00000000, 0xFFFFFFFF, 0x12345678, 0x12345678, 0x9ABCDEF0, … Required response:
   - the first two words and the duplicate are rejected with no strobe;
   - `key_index` 0 = 0x12345678 and `key_index` 1 = 0x9ABCDEF0;
   - load completes.
3. **Retry exhaustion.** The TRNG returns 0x00000000 four times in a row. Required response:
   - `error` = 1 after the fourth CHECK;
   - `busy` = 0, `trng_request` = 0, no strobes;
   - a subsequent `start` clears `error` and loads normally.
4. **Timeout.** `trng_ready` is held at 0 after `start`. Required response: `error` = 1 exactly `TIMEOUT_CYCLES` cycles after `trng_request` rises. A second run with `trng_ready` stuck at 1 after the first word must time out in WAIT_LOW.
5. **Reset mid-load.** Assert `rst` after the third strobe. Required response:
   - the next cycle shows all outputs 0 and the state IDLE;
   - after a new `start` the strobes restart at `key_index` 0.
6. **Start while busy.** Pulse `start` repeatedly during a load. Required response: the strobe sequence and timing are identical to scenario 1.

Source files
------------

// File: rtl/trng_key_collector_if.sv
// TRNG request/ready handshake plus the indexed key-register write bus.
// The master side is the collector. The slave side is the TRNG and key-core pair.
interface trng_key_collector_if;
    logic        trng_request;
    logic        trng_ready;
    logic [31:0] trng_random_number;
    logic        key_write_enable;
    logic [2:0]  key_index;
    logic [31:0] key_word;

    modport master (
        output trng_request, key_write_enable, key_index, key_word,
        input  trng_ready, trng_random_number
    );

    modport slave (
        input  trng_request, key_write_enable, key_index, key_word,
        output trng_ready, trng_random_number
    );
endinterface

// File: rtl/trng_key_collector.sv
// Pulls KEY_WORDS health-checked words from the TRNG and strobes them into the
// ChaCha20 key registers. Repeated rejects or a stalled handshake end in ERROR.
// Every output is registered and is derived from the next state.
module trng_key_collector #(
    parameter int KEY_WORDS      = 8,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int MAX_RETRIES    = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    trng_key_collector_if.master bus,
    output logic                 key_loading_done,
    output logic                 busy,
    output logic                 error
);
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int RW = $clog2(MAX_RETRIES + 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);
    localparam logic [2:0]    LAST_IDX  = 3'(KEY_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_WAIT_LOW, S_CHECK, S_WRITE, S_DONE, S_ERROR
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    word_cnt_q, word_cnt_d;
    logic [RW-1:0] retry_q, retry_d, retry_inc;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [31:0]   word_q, word_d;
    logic [31:0]   prev_q, prev_d;
    logic          have_prev_q, have_prev_d;
    logic          req_q, req_d;
    logic          kwe_q, kwe_d;
    logic [2:0]    kidx_q, kidx_d;
    logic [31:0]   kword_q, kword_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
    logic          err_q, err_d;
    logic          reject;

    // Next-state and next-output logic for the collector FSM
    always_comb begin
        state_d     = state_q;
        word_cnt_d  = word_cnt_q;
        retry_d     = retry_q;
        tmo_d       = tmo_q;
        word_d      = word_q;
        prev_d      = prev_q;
        have_prev_d = have_prev_q;
        kwe_d       = 1'b0;
        kidx_d      = 3'd0;
        kword_d     = 32'd0;
        retry_inc   = retry_q + 1'b1;
        // A stuck-at-0/1 word or a repeat of the last accepted word is not trusted.
        reject      = (word_q == 32'h0000_0000) || (word_q == 32'hFFFF_FFFF) ||
                      (have_prev_q && (word_q == prev_q));

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d     = S_REQ;
                    word_cnt_d  = 3'd0;
                    retry_d     = '0;
                    have_prev_d = 1'b0;
                    tmo_d       = '0;
                end
            end
            S_REQ: begin
                if (bus.trng_ready) begin
                    word_d  = bus.trng_random_number;
                    state_d = S_WAIT_LOW;
                    tmo_d   = '0;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_ERROR;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_WAIT_LOW: begin
                if (!bus.trng_ready) begin
                    state_d = S_CHECK;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_ERROR;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_CHECK: begin
                if (reject) begin
                    retry_d = retry_inc;
                    if (retry_inc == RETRY_MAX) begin
                        state_d = S_ERROR;
                    end else begin
                        state_d = S_REQ;
                        tmo_d   = '0;
                    end
                end else begin
                    retry_d     = '0;
                    prev_d      = word_q;
                    have_prev_d = 1'b1;
                    state_d     = S_WRITE;
                    kwe_d       = 1'b1;
                    kidx_d      = word_cnt_q;
                    kword_d     = word_q;
                end
            end
            S_WRITE: begin
                word_d = 32'd0;
                if (word_cnt_q == LAST_IDX) begin
                    state_d = S_DONE;
                    prev_d  = 32'd0;
                end else begin
                    word_cnt_d = word_cnt_q + 3'd1;
                    state_d    = S_REQ;
                    tmo_d      = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Key material must not linger once the block gives up.
        if (state_d == S_ERROR && state_q != S_ERROR) begin
            word_d = 32'd0;
            prev_d = 32'd0;
        end

        req_d  = (state_d == S_REQ);
        done_d = (state_d == S_DONE);
        err_d  = (state_d == S_ERROR);
        busy_d = !(state_d == S_IDLE || state_d == S_DONE || state_d == S_ERROR);
    end

    // State and registered outputs. Reset clears everything and returns to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            word_cnt_q  <= 3'd0;
            retry_q     <= '0;
            tmo_q       <= '0;
            word_q      <= 32'd0;
            prev_q      <= 32'd0;
            have_prev_q <= 1'b0;
            req_q       <= 1'b0;
            kwe_q       <= 1'b0;
            kidx_q      <= 3'd0;
            kword_q     <= 32'd0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_cnt_q  <= word_cnt_d;
            retry_q     <= retry_d;
            tmo_q       <= tmo_d;
            word_q      <= word_d;
            prev_q      <= prev_d;
            have_prev_q <= have_prev_d;
            req_q       <= req_d;
            kwe_q       <= kwe_d;
            kidx_q      <= kidx_d;
            kword_q     <= kword_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    assign bus.trng_request     = req_q;
    assign bus.key_write_enable = kwe_q;
    assign bus.key_index        = kidx_q;
    assign bus.key_word         = kword_q;
    assign key_loading_done     = done_q;
    assign busy                 = busy_q;
    assign error                = err_q;
endmodule
